regfile_wr_arbiter: RTL and testbench

//  Shares the single regfile write port between the in-order WB stage and one long-latency

---
 rtl/regfile_wr_arbiter_pkg.sv | 18 +
 rtl/regfile_wr_arbiter_fifo.sv | 92 +++++++++
 rtl/regfile_wr_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and constants for the regfile write-port arbiter and its LU result buffer.
package regfile_wr_arbiter_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = '0;
   localparam logic [REG_DATA_W-1:0] ZERO_WORD = '0;

   typedef enum logic [1:0] {
      ENT_EMPTY    = 2'd0,
      ENT_VALID    = 2'd1,
      ENT_SQUASHED = 2'd2
   } ent_state_e;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } rf_wr_t;
endpackage

// File: rtl/regfile_wr_arbiter_fifo.sv
// LU result buffer: circular queue of {state, addr, data} with per-entry squash-by-address.
module regwr_fifo
   import regfile_wr_arbiter_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             push,
   input  logic [REG_ADDR_W-1:0]            push_addr,
   input  logic [REG_DATA_W-1:0]            push_data,
   input  logic                             pop,
   input  logic                             squash_en,
   input  logic [REG_ADDR_W-1:0]            squash_addr,
   output logic                             head_occ,
   output logic                             head_valid,
   output logic [REG_ADDR_W-1:0]            head_addr,
   output logic [REG_DATA_W-1:0]            head_data,
   output logic                             full,
   output logic [CNT_W-1:0]                 cnt,
   output logic [DEPTH-1:0]                 ent_valid,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr
);
   localparam int PTR_W = $clog2(DEPTH);

   ent_state_e       st_q  [DEPTH];
   ent_state_e       st_d  [DEPTH];
   rf_wr_t           ent_q [DEPTH];
   rf_wr_t           ent_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      st_d   = st_q;
      ent_d  = ent_q;
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      // A younger WB write to the same register makes the buffered value dead.
      for (int i = 0; i < DEPTH; i++) begin
         if (squash_en && st_q[i] == ENT_VALID && ent_q[i].addr == squash_addr)
            st_d[i] = ENT_SQUASHED;
      end
      if (pop) begin
         st_d[head_q] = ENT_EMPTY;
         head_d       = head_q + PTR_W'(1);
      end
      // The tail slot is always empty when pushing, so a same-cycle squash cannot hit it.
      if (push) begin
         st_d[tail_q]  = ENT_VALID;
         ent_d[tail_q] = '{addr: push_addr, data: push_data};
         tail_d        = tail_q + PTR_W'(1);
      end
      if (push && !pop)
         cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !push)
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            st_q[i]  <= ENT_EMPTY;
            ent_q[i] <= '0;
         end
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         st_q   <= st_d;
         ent_q  <= ent_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   assign head_occ   = (st_q[head_q] != ENT_EMPTY);
   assign head_valid = (st_q[head_q] == ENT_VALID);
   assign head_addr  = ent_q[head_q].addr;
   assign head_data  = ent_q[head_q].data;
   assign full       = (cnt_q == CNT_W'(DEPTH));
   assign cnt        = cnt_q;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_valid[i] = (st_q[i] == ENT_VALID);
         ent_addr[i]  = ent_q[i].addr;
      end
   end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile write port between WB (always wins) and a buffered long-latency unit;
// also reports buffered-destination hazards and requests a stall when the buffer head starves.
module regfile_wr_arbiter
   import regfile_wr_arbiter_pkg::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_waddr,
   input  logic [REG_DATA_W-1:0] wb_wdata,
   input  logic                  lu_valid,
   output logic                  lu_ready,
   input  logic [REG_ADDR_W-1:0] lu_waddr,
   input  logic [REG_DATA_W-1:0] lu_wdata,
   input  logic [REG_ADDR_W-1:0] raddr1,
   input  logic [REG_ADDR_W-1:0] raddr2,
   output logic                  hazard1,
   output logic                  hazard2,
   output logic                  stall_req,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [REG_DATA_W-1:0] rf_wdata,
   output logic [CNT_W-1:0]      pend_cnt
);
   localparam int               AGE_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

   logic                             wb_act, push, pop;
   logic                             head_occ, head_valid, full;
   logic [REG_ADDR_W-1:0]            head_addr;
   logic [REG_DATA_W-1:0]            head_data;
   logic [CNT_W-1:0]                 cnt;
   logic [DEPTH-1:0]                 ent_valid;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr;
   logic [AGE_W-1:0]                 age_q, age_d;

   // A WB write to r0 is architecturally a no-op, so it leaves the port free for the buffer.
   assign wb_act   = wb_we && (wb_waddr != ZERO_ADDR);
   assign lu_ready = !rst && !full;
   assign push     = lu_valid && lu_ready && (lu_waddr != ZERO_ADDR);
   assign pop      = head_occ && (!head_valid || !wb_act);

   regwr_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_addr  (lu_waddr),
      .push_data  (lu_wdata),
      .pop        (pop),
      .squash_en  (wb_act),
      .squash_addr(wb_waddr),
      .head_occ   (head_occ),
      .head_valid (head_valid),
      .head_addr  (head_addr),
      .head_data  (head_data),
      .full       (full),
      .cnt        (cnt),
      .ent_valid  (ent_valid),
      .ent_addr   (ent_addr)
   );

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = ZERO_ADDR;
      rf_wdata = ZERO_WORD;
      if (!rst) begin
         if (wb_act) begin
            rf_we    = 1'b1;
            rf_waddr = wb_waddr;
            rf_wdata = wb_wdata;
         end else if (head_valid) begin
            rf_we    = 1'b1;
            rf_waddr = head_addr;
            rf_wdata = head_data;
         end
      end
   end

   always_comb begin
      age_d = age_q;
      if (pop || !head_valid)
         age_d = '0;
      else if (wb_act && age_q != AGE_MAX)
         age_d = age_q + AGE_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) age_q <= '0;
      else     age_q <= age_d;
   end

   assign stall_req = !rst && (age_q == AGE_MAX);
   assign pend_cnt  = rst ? '0 : cnt;

   always_comb begin
      hazard1 = 1'b0;
      hazard2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_valid[i] && ent_addr[i] == raddr1) hazard1 = 1'b1;
         if (ent_valid[i] && ent_addr[i] == raddr2) hazard2 = 1'b1;
      end
      if (rst || raddr1 == ZERO_ADDR) hazard1 = 1'b0;
      if (rst || raddr2 == ZERO_ADDR) hazard2 = 1'b0;
   end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: scoreboard of buffered LU results plus scenario tasks.
module tb_regfile_wr_arbiter;
   localparam int DEPTH = 2;

   logic        clk;
   logic        rst;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_waddr;
   logic [31:0] lu_wdata;
   logic [4:0]  raddr1, raddr2;
   logic        hazard1, hazard2, stall_req;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [1:0]  pend_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      bit          vld;
   } sb_ent_t;

   sb_ent_t     sbq[$];
   logic [31:0] shadow [32];

   regfile_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(4), .CNT_W(2)) dut (
      .clk(clk), .rst(rst),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
      .raddr1(raddr1), .raddr2(raddr2), .hazard1(hazard1), .hazard2(hazard2),
      .stall_req(stall_req), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .pend_cnt(pend_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One clock cycle with the currently driven inputs: compare outputs against the model, then commit.
   task automatic tick();
      bit          wb_act, exp_we, exp_rdy, hz1, hz2, do_pop;
      logic [4:0]  exp_a;
      logic [31:0] exp_d;
      #1;
      if (rst) begin
         sbq.delete();
      end else begin
         wb_act  = wb_we && (wb_waddr != 5'd0);
         exp_rdy = (sbq.size() < DEPTH);
         do_pop  = 0;
         exp_we  = 0;
         exp_a   = 5'd0;
         exp_d   = 32'd0;
         if (wb_act) begin
            exp_we = 1; exp_a = wb_waddr; exp_d = wb_wdata;
         end
         if (sbq.size() > 0) begin
            if (!sbq[0].vld) do_pop = 1;
            else if (!wb_act) begin
               do_pop = 1; exp_we = 1; exp_a = sbq[0].addr; exp_d = sbq[0].data;
            end
         end
         hz1 = 0;
         hz2 = 0;
         foreach (sbq[i]) begin
            if (sbq[i].vld && raddr1 != 5'd0 && sbq[i].addr == raddr1) hz1 = 1;
            if (sbq[i].vld && raddr2 != 5'd0 && sbq[i].addr == raddr2) hz2 = 1;
         end
         checks++;
         if ({rf_we, rf_waddr, rf_wdata} !== {exp_we, exp_a, exp_d}) begin
            errors++;
            $display("FAIL sb_rf_write: got we=%0b a=%0d d=%h, expected we=%0b a=%0d d=%h",
                     rf_we, rf_waddr, rf_wdata, exp_we, exp_a, exp_d);
         end
         checks++;
         if (pend_cnt !== 2'(sbq.size())) begin
            errors++;
            $display("FAIL sb_pend_cnt: got %0d expected %0d", pend_cnt, sbq.size());
         end
         checks++;
         if (lu_ready !== exp_rdy) begin
            errors++;
            $display("FAIL sb_lu_ready: got %0b expected %0b", lu_ready, exp_rdy);
         end
         checks++;
         if ({hazard1, hazard2} !== {hz1, hz2}) begin
            errors++;
            $display("FAIL sb_hazard: got %0b%0b expected %0b%0b", hazard1, hazard2, hz1, hz2);
         end
         if (rf_we === 1'b1) shadow[rf_waddr] = rf_wdata;
         if (do_pop) void'(sbq.pop_front());
         if (wb_act) foreach (sbq[i]) if (sbq[i].addr == wb_waddr) sbq[i].vld = 0;
         if (lu_valid && exp_rdy && lu_waddr != 5'd0)
            sbq.push_back('{addr: lu_waddr, data: lu_wdata, vld: 1'b1});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_wb(input bit we, input logic [4:0] a, input logic [31:0] d);
      wb_we = we; wb_waddr = a; wb_wdata = d;
   endtask

   task automatic set_lu(input bit v, input logic [4:0] a, input logic [31:0] d);
      lu_valid = v; lu_waddr = a; lu_wdata = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_wb(1, 5'd9, 32'h1234_5678);
      set_lu(1, 5'd4, 32'hABCD);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if ({rf_we, lu_ready, pend_cnt, stall_req} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs: got rf_we=%0b lu_ready=%0b pend_cnt=%0d stall=%0b, expected all 0",
                  rf_we, lu_ready, pend_cnt, stall_req);
      end
      checks++;
      if ({rf_waddr, rf_wdata} !== 37'd0) begin
         errors++;
         $display("FAIL reset_rf_bus: got a=%0d d=%h expected 0", rf_waddr, rf_wdata);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      set_wb(0, 5'd0, 32'd0);
      set_lu(0, 5'd0, 32'd0);
      #1;
      checks++;
      if (lu_ready !== 1'b1 || pend_cnt !== 2'd0) begin
         errors++;
         $display("FAIL reset_release: got lu_ready=%0b pend_cnt=%0d expected 1 and 0", lu_ready, pend_cnt);
      end
      sbq.delete();
   endtask

   task automatic test_idle_drain();
      set_lu(1, 5'd5, 32'hDEAD);
      tick();
      set_lu(0, 5'd0, 32'd0);
      #1;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEAD}) begin
         errors++;
         $display("FAIL idle_drain_write: got we=%0b a=%0d d=%h expected we=1 a=5 d=dead",
                  rf_we, rf_waddr, rf_wdata);
      end
      tick();
      checks++;
      if (pend_cnt !== 2'd0) begin
         errors++;
         $display("FAIL idle_drain_empty: got pend_cnt=%0d expected 0", pend_cnt);
      end
   endtask

   task automatic test_priority_full();
      set_wb(1, 5'd10, 32'hA0);
      set_lu(1, 5'd3, 32'h3);
      tick();
      set_wb(1, 5'd11, 32'hA1);
      set_lu(1, 5'd4, 32'h4);
      tick();
      set_wb(1, 5'd12, 32'hA2);
      set_lu(1, 5'd6, 32'h6);
      raddr1 = 5'd3;
      raddr2 = 5'd4;
      #1;
      checks++;
      if ({pend_cnt, lu_ready, hazard1} !== {2'd2, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL prio_full: got pend_cnt=%0d lu_ready=%0b hazard1=%0b expected 2 0 1",
                  pend_cnt, lu_ready, hazard1);
      end
      tick();
      set_wb(0, 5'd0, 32'd0);
      set_lu(0, 5'd0, 32'd0);
      tick();
      tick();
      raddr1 = 5'd0;
      raddr2 = 5'd0;
   endtask

   task automatic test_starvation();
      set_lu(1, 5'd3, 32'h333);
      tick();
      set_lu(0, 5'd0, 32'd0);
      set_wb(1, 5'd12, 32'hC0);
      for (int i = 1; i <= 6; i++) begin
         tick();
         #1;
         checks++;
         if (stall_req !== (i >= 4)) begin
            errors++;
            $display("FAIL starve_cnt%0d: got stall_req=%0b expected %0b", i, stall_req, (i >= 4));
         end
      end
      set_wb(0, 5'd0, 32'd0);
      #1;
      checks++;
      if (stall_req !== 1'b1) begin
         errors++;
         $display("FAIL starve_hold: got stall_req=%0b expected 1", stall_req);
      end
      tick();
      #1;
      checks++;
      if (stall_req !== 1'b0 || shadow[3] !== 32'h333) begin
         errors++;
         $display("FAIL starve_release: got stall_req=%0b r3=%h expected 0 and 333", stall_req, shadow[3]);
      end
   endtask

   task automatic test_waw_squash();
      set_lu(1, 5'd7, 32'h11);
      tick();
      set_lu(0, 5'd0, 32'd0);
      set_wb(1, 5'd7, 32'h22);
      raddr1 = 5'd7;
      #1;
      checks++;
      if (hazard1 !== 1'b1) begin
         errors++;
         $display("FAIL waw_hazard_before: got hazard1=%0b expected 1", hazard1);
      end
      tick();
      set_wb(0, 5'd0, 32'd0);
      #1;
      checks++;
      if (hazard1 !== 1'b0 || rf_we !== 1'b0) begin
         errors++;
         $display("FAIL waw_squashed_pop: got hazard1=%0b rf_we=%0b expected 0 0", hazard1, rf_we);
      end
      tick();
      raddr1 = 5'd0;
      checks++;
      if (pend_cnt !== 2'd0 || shadow[7] !== 32'h22) begin
         errors++;
         $display("FAIL waw_final: got pend_cnt=%0d r7=%h expected 0 and 22", pend_cnt, shadow[7]);
      end
      // squashed head leaves while WB keeps the port busy
      set_lu(1, 5'd8, 32'h88);
      tick();
      set_lu(0, 5'd0, 32'd0);
      set_wb(1, 5'd8, 32'h89);
      tick();
      set_wb(1, 5'd9, 32'h99);
      #1;
      checks++;
      if (pend_cnt !== 2'd1) begin
         errors++;
         $display("FAIL waw_busy_pre: got pend_cnt=%0d expected 1", pend_cnt);
      end
      tick();
      set_wb(0, 5'd0, 32'd0);
      #1;
      checks++;
      if (pend_cnt !== 2'd0 || shadow[8] !== 32'h89) begin
         errors++;
         $display("FAIL waw_busy_pop: got pend_cnt=%0d r8=%h expected 0 and 89", pend_cnt, shadow[8]);
      end
      // an LU push in the same cycle as a matching WB write is the younger value
      set_wb(1, 5'd9, 32'h9A);
      set_lu(1, 5'd9, 32'h9B);
      tick();
      set_wb(0, 5'd0, 32'd0);
      set_lu(0, 5'd0, 32'd0);
      tick();
      checks++;
      if (shadow[9] !== 32'h9B) begin
         errors++;
         $display("FAIL waw_same_cycle: got r9=%h expected 9b", shadow[9]);
      end
   endtask

   task automatic test_edge_cases();
      set_lu(1, 5'd0, 32'h5);
      tick();
      set_lu(0, 5'd0, 32'd0);
      #1;
      checks++;
      if (pend_cnt !== 2'd0) begin
         errors++;
         $display("FAIL edge_lu_r0: got pend_cnt=%0d expected 0", pend_cnt);
      end
      set_lu(1, 5'd2, 32'h2222);
      tick();
      set_lu(0, 5'd0, 32'd0);
      set_wb(1, 5'd0, 32'h999);
      #1;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd2, 32'h2222}) begin
         errors++;
         $display("FAIL edge_wb_r0_drain: got we=%0b a=%0d d=%h expected we=1 a=2 d=2222",
                  rf_we, rf_waddr, rf_wdata);
      end
      tick();
      set_wb(0, 5'd0, 32'd0);
      tick();
   endtask

   task automatic test_reset_midop();
      set_lu(1, 5'd14, 32'hE);
      tick();
      set_lu(0, 5'd0, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (pend_cnt !== 2'd0 || rf_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_midop: got pend_cnt=%0d rf_we=%0b expected 0 0", pend_cnt, rf_we);
      end
      tick();
   endtask

   initial begin
      rst = 1'b1;
      wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
      lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
      raddr1 = '0; raddr2 = '0;
      for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
      test_reset();
      test_idle_drain();
      test_priority_full();
      test_starvation();
      test_waw_squash();
      test_edge_cases();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
